// File: rtl/riscv_cache_fill_ctrl.sv
// Cache line fill / evict / flush sequencer.
// Drives the BIU for victim write-back and line refill, and scans every way for flush.
module riscv_cache_fill_ctrl #(
    parameter int XLEN          = 32,
    parameter int WAYS          = 2,
    parameter int IDX_BITS      = 5,
    parameter int BLK_OFFS_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [XLEN-1:0]     req_adr_i,
    input  logic                hit_i,
    input  logic                way_dirty_i,
    input  logic [XLEN-1:0]     evict_adr_i,
    input  logic                flush_req_i,
    output logic                armed_o,
    output logic                flushing_o,
    output logic                filling_o,
    output logic [WAYS-1:0]     fill_way_select_o,
    output logic [IDX_BITS-1:0] flush_idx_o,
    output logic                biu_req_o,
    output logic                biu_we_o,
    output logic [XLEN-1:0]     biu_adr_o,
    input  logic                biu_ack_i,
    input  logic                biucmd_ack_i,
    output logic                stall_o,
    output logic                flush_done_o
);

    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_ARMED,
        S_EVICT,
        S_FILL,
        S_RECOVER,
        S_FL_RD,
        S_FL_WB,
        S_FL_CLR
    } state_e;

    state_e                state_q, state_d;
    logic [WAYS-1:0]       victim_q, victim_d;
    logic [XLEN-1:0]       evict_adr_q, evict_adr_d;
    logic [XLEN-1:0]       fill_adr_q, fill_adr_d;
    logic                  sent_q, sent_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic [1:0]            wait_q, wait_d;
    logic                  adv;
    logic [WAYS-1:0]       scan_sel;
    logic [XLEN-1:0]       line_mask;

    assign scan_sel  = WAYS'(1) << way_q;
    assign line_mask = {XLEN{1'b1}} << BLK_OFFS_BITS;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_ARMED;
            victim_q    <= WAYS'(1);
            evict_adr_q <= '0;
            fill_adr_q  <= '0;
            sent_q      <= 1'b0;
            idx_q       <= '0;
            way_q       <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            evict_adr_q <= evict_adr_d;
            fill_adr_q  <= fill_adr_d;
            sent_q      <= sent_d;
            idx_q       <= idx_d;
            way_q       <= way_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        evict_adr_d       = evict_adr_q;
        fill_adr_d        = fill_adr_q;
        sent_d            = sent_q;
        idx_d             = idx_q;
        way_d             = way_q;
        wait_d            = wait_q;
        adv               = 1'b0;
        armed_o           = 1'b0;
        flushing_o        = 1'b0;
        filling_o         = 1'b0;
        fill_way_select_o = victim_q;
        flush_idx_o       = idx_q;
        biu_req_o         = 1'b0;
        biu_we_o          = 1'b0;
        biu_adr_o         = '0;
        stall_o           = 1'b1;
        flush_done_o      = 1'b0;

        unique case (state_q)
            S_ARMED: begin
                armed_o = 1'b1;
                stall_o = (req_i & ~hit_i) | flush_req_i;
                if (flush_req_i) begin
                    state_d = S_FL_RD;
                    idx_d   = '0;
                    way_d   = '0;
                    wait_d  = '0;
                end else if (req_i && !hit_i) begin
                    evict_adr_d = evict_adr_i;
                    fill_adr_d  = req_adr_i & line_mask;
                    sent_d      = 1'b0;
                    state_d     = way_dirty_i ? S_EVICT : S_FILL;
                end
            end
            S_EVICT: begin
                biu_req_o = 1'b1;
                biu_we_o  = 1'b1;
                biu_adr_o = evict_adr_q;
                if (biu_ack_i) state_d = S_FILL;
            end
            S_FILL: begin
                filling_o = 1'b1;
                biu_req_o = ~sent_q;
                biu_adr_o = fill_adr_q;
                if (biu_ack_i && !sent_q) sent_d = 1'b1;
                if (biucmd_ack_i) state_d = S_RECOVER;
            end
            S_RECOVER: begin
                // Round-robin replacement: next victim is the next way up.
                victim_d = (victim_q << 1) | (victim_q >> (WAYS - 1));
                state_d  = S_ARMED;
            end
            S_FL_RD: begin
                fill_way_select_o = scan_sel;
                if (wait_q != 2'd2) begin
                    wait_d = wait_q + 2'd1;
                end else if (way_dirty_i) begin
                    evict_adr_d = evict_adr_i;
                    state_d     = S_FL_WB;
                end else begin
                    adv = 1'b1;
                end
            end
            S_FL_WB: begin
                fill_way_select_o = scan_sel;
                biu_req_o         = 1'b1;
                biu_we_o          = 1'b1;
                biu_adr_o         = evict_adr_q;
                if (biu_ack_i) adv = 1'b1;
            end
            S_FL_CLR: begin
                flushing_o   = 1'b1;
                flush_done_o = 1'b1;
                idx_d        = '0;
                way_d        = '0;
                state_d      = S_ARMED;
            end
            default: state_d = S_ARMED;
        endcase

        if (adv) begin
            wait_d  = '0;
            state_d = S_FL_RD;
            if (way_q == WAY_BITS'(WAYS - 1)) begin
                way_d = '0;
                if (idx_q == {IDX_BITS{1'b1}}) state_d = S_FL_CLR;
                else idx_d = idx_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/riscv_cache_fill_ctrl.md
RISCV_CACHE_FILL_CTRL -- requirements
Module: riscv_cache_fill_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter WAYS, default 2, number of cache ways.
REQ-003 SHALL have parameter IDX_BITS, default 5, set-index width (SETS = 2**IDX_BITS).
REQ-004 SHALL have parameter BLK_OFFS_BITS, default 4, byte-offset bits within a line.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  reset.
REQ-006 SHALL have: req_i  input  1  core access valid; req_adr_i  input  XLEN  core address.
REQ-007 SHALL have: hit_i  input  1  registered hit from cache memory; way_dirty_i  input  1  selected way valid&dirty.
REQ-008 SHALL have: evict_adr_i  input  XLEN  line address of victim; flush_req_i  input  1  flush request.
REQ-009 SHALL have: armed_o, flushing_o, filling_o  output  1 each  cache-memory mode controls.
REQ-010 SHALL have: fill_way_select_o  output  WAYS  one-hot way; flush_idx_o  output  IDX_BITS  scan index.
REQ-011 SHALL have: biu_req_o  output  1; biu_we_o  output  1; biu_adr_o  output  XLEN; biu_ack_i  input  1  command accepted; biucmd_ack_i  input  1  line transfer done.
REQ-012 SHALL have: stall_o  output  1  core stall; flush_done_o  output  1  one-cycle flush completion pulse.

Function
REQ-013 SHALL implement states ARMED, EVICT, FILL, RECOVER, FL_RD, FL_WB, FL_CLR.
REQ-014 ARMED: flush_req_i -> FL_RD (priority over miss); else req_i & !hit_i & way_dirty_i -> EVICT; else req_i & !hit_i -> FILL.
REQ-015 EVICT: biu_req_o=1, biu_we_o=1, biu_adr_o=evict_adr_i captured on ARMED exit; biu_ack_i -> FILL.
REQ-016 FILL: filling_o=1, biu_req_o=1 until biu_ack_i then 0, biu_we_o=0, biu_adr_o=req_adr_i with low BLK_OFFS_BITS cleared, captured on ARMED exit; biucmd_ack_i -> RECOVER.
REQ-017 RECOVER: one cycle, stall held, victim pointer rotates left by one (MSB wraps to bit 0), -> ARMED.
REQ-018 Victim pointer: one-hot, drives fill_way_select_o in ARMED/EVICT/FILL/RECOVER; frozen outside RECOVER.
REQ-019 FL_RD: fill_way_select_o=scan-way one-hot, flush_idx_o=scan index; wait 2 cycles (memory latency), then way_dirty_i ? FL_WB : advance.
REQ-020 FL_WB: biu_req_o=1, biu_we_o=1, biu_adr_o=evict_adr_i; biu_ack_i -> advance.
REQ-021 Advance: way increments first; at way WAYS-1 way wraps to 0 and index increments; after index SETS-1/way WAYS-1 -> FL_CLR.
REQ-022 FL_CLR: flushing_o=1 one cycle, flush_done_o=1 same cycle, index/way counters reset to 0, -> ARMED.
REQ-023 armed_o=1 only in ARMED; filling_o=1 only in FILL; flushing_o=1 only in FL_CLR.
REQ-024 stall_o=1 in every state except ARMED; in ARMED stall_o=req_i & !hit_i | flush_req_i (combinational).
REQ-025 biu_req_o SHALL stay asserted with stable biu_adr_o/biu_we_o until biu_ack_i; never asserted in ARMED, RECOVER, FL_RD, FL_CLR.
REQ-026 biucmd_ack_i outside FILL and biu_ack_i outside request states SHALL be ignored.
REQ-027 flush_req_i asserted while not in ARMED SHALL be ignored (requester holds it until flush_done_o).

Reset
REQ-028 On rst_ni=0: state ARMED, victim pointer 1 (way 0), scan index/way 0, captured addresses 0.
REQ-029 During reset: armed_o=1, all other outputs 0 except fill_way_select_o=1; reset mid-transfer SHALL abandon transfer, no pulse.

Verification
REQ-030 Clean miss: req_i=1, hit_i=0, way_dirty_i=0, req_adr_i=0x0000_1234 -> FILL, biu_adr_o=0x0000_1230, biu_we_o=0; biucmd_ack_i -> RECOVER -> ARMED, fill_way_select_o 01->10.
REQ-031 Dirty miss: way_dirty_i=1, evict_adr_i=0x0000_8000 -> EVICT write to 0x0000_8000, biu_ack_i -> FILL read of miss line.
REQ-032 Rotation wrap: WAYS=2, three fills -> select 01,10,01.
REQ-033 Flush with one dirty line at idx 3 way 1 -> exactly one FL_WB, FL_CLR after 64 scan steps, flushing_o and flush_done_o high one cycle.
REQ-034 Simultaneous flush_req_i and miss in ARMED -> FL_RD entered, miss served after flush_done_o.
REQ-035 rst_ni low during FILL with biu_req_o=1 -> next cycle armed_o=1, biu_req_o=0, filling_o=0.
